uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of byte requesters (2..8).
REQ-002 SHALL have parameter DIV_W, default 16: width of the baud divisor.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: per-requester byte valid.
REQ-006 SHALL have port req_data, input, NUM_REQ*8 bits: per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port req_ready, output, NUM_REQ bits: one-hot accept strobe.
REQ-008 SHALL have port baud_div, input, DIV_W bits: clocks per bit minus 1.
REQ-009 SHALL have port cts, input, 1 bit: clear-to-send, active-high.
REQ-010 SHALL have port stx, output, 1 bit: serial transmit line.
REQ-011 SHALL have port rts, output, 1 bit: request-to-send.
REQ-012 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-013 SHALL have port grant_id, output, $clog2(NUM_REQ) bits: index of the last accepted requester.

Function
REQ-014 SHALL use FSM states IDLE, START, DATA and STOP.
REQ-015 SHALL perform an accept in IDLE when any req_valid is high and the gate is open; the winner is the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-016 SHALL drive req_ready[winner] high combinationally in the accept cycle only; all other bits SHALL be 0; the byte and baud_div SHALL be latched in that cycle.
REQ-017 SHALL, on an accept, set rr_ptr to (winner+1) mod NUM_REQ and grant_id to winner, both effective the next cycle.
REQ-018 SHALL go from IDLE to START on the cycle after an accept.
REQ-019 SHALL hold every bit for exactly latched_div+1 cycles; baud_div=0 gives 1 cycle per bit.
REQ-020 SHALL transmit a frame as START (stx=0), then DATA (8 bits, LSB first), then STOP (stx=1), then return to IDLE.
REQ-021 SHALL make one frame occupy 10*(div+1) cycles; back-to-back frames SHALL have a period of 10*(div+1)+1 cycles, including the accept cycle in IDLE.
REQ-022 SHALL ignore changes to baud_div and req_data during a frame.
REQ-023 SHALL hold stx at 1 in IDLE.
REQ-024 SHALL drive busy high in START, DATA and STOP, and low in IDLE.
REQ-025 SHALL register rts as (|req_valid) | busy, with one cycle of latency.
REQ-026 SHALL let a requester dropping valid before it is accepted lose the arbitration without side effects.

Reset
REQ-027 SHALL, when rst_n is low at a clk edge, set: state=IDLE, stx=1, rts=0, busy=0, grant_id=0, rr_ptr=0, and all counters to 0.
REQ-028 SHALL keep req_ready at 0 while rst_n is low.
REQ-029 SHALL, on reset mid-frame, abandon the frame; stx SHALL be 1 from the next cycle and no further accept SHALL occur until rst_n is high.

Configuration
REQ-030 SHALL, with macro UART_TX_SCHED_CTS_EN defined, open the accept gate only when cts=1.
REQ-031 SHALL, with UART_TX_SCHED_CTS_EN defined, let cts falling mid-frame only block the next accept; the current frame SHALL complete.
REQ-032 SHALL, without UART_TX_SCHED_CTS_EN, ignore cts and keep the gate always open.

Structure
REQ-033 SHALL place in package uart_tx_sched_pkg: the state enum (IDLE, START, DATA, STOP), the FRAME_BITS=10 constant, and the DATA_BITS=8 constant.
REQ-034 SHALL split the design into a round-robin arbiter plus FSM in uart_tx_sched, and bit timing plus shift register in sub-module uart_tx_ser (inputs load/byte/div; outputs stx/done).

Verification
REQ-035 SHALL verify single frame: div=3, req 0 sends 0xA5 -> stx low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; busy high for 40 cycles.
REQ-036 SHALL verify round-robin: all 4 valid continuously, div=0 -> grant order 0,1,2,3,0; accepts 11 cycles apart.
REQ-037 SHALL verify skipping: after grant 1, only req 0 and req 3 valid -> next grant 3, then 0.
REQ-038 SHALL verify CTS gating (macro on): cts=0 with req 2 valid -> no req_ready and rts=1; cts rises -> accept next cycle; cts drops mid-frame -> frame completes.
REQ-039 SHALL verify reset mid-frame: rst_n low during DATA bit 3 -> next cycle stx=1, busy=0, grant_id=0; first grant after release is the lowest valid index.
REQ-040 SHALL verify divisor latch: baud_div changed from 2 to 9 mid-frame -> current frame keeps 3 cycles/bit; next frame uses 10.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
`default_nettype none
// ============================================================================
// uart_tx_sched_pkg : shared FSM state type and frame constants
// Revision: 1.0
// ============================================================================
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

endpackage
`default_nettype wire

// File: rtl/uart_tx_ser.sv
`default_nettype none
// ============================================================================
// uart_tx_ser : per-frame bit timing and shift register for uart_tx_sched
// Revision: 1.0
// ============================================================================
module uart_tx_ser
  import uart_tx_sched_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [DATA_BITS-1:0] byte_i,
  input  logic [DIV_W-1:0]     div_i,
  output logic                 stx_o,
  output logic                 tick_o,
  output logic                 done_o
);

  localparam int BIT_W = $clog2(FRAME_BITS);

  logic [FRAME_BITS-1:0] shift_q;
  logic [DIV_W-1:0]      div_q;
  logic [DIV_W-1:0]      cnt_q;
  logic [BIT_W-1:0]      bit_q;
  logic                  active_q;

  // tick marks the last clock of the current bit; done marks the last clock of the stop bit
  assign tick_o = active_q && (cnt_q == div_q);
  assign done_o = tick_o && (bit_q == BIT_W'(FRAME_BITS - 1));
  assign stx_o  = active_q ? shift_q[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q  <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
    end else if (load_i) begin
      shift_q  <= {1'b1, byte_i, 1'b0};
      div_q    <= div_i;
      cnt_q    <= '0;
      bit_q    <= '0;
      active_q <= 1'b1;
    end else if (tick_o) begin
      cnt_q   <= '0;
      shift_q <= {1'b1, shift_q[FRAME_BITS-1:1]};
      bit_q   <= bit_q + 1'b1;
      if (done_o) begin
        active_q <= 1'b0;
      end
    end else if (active_q) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// uart_tx_sched : round-robin byte scheduler feeding one UART transmitter.
// Optional macro UART_TX_SCHED_CTS_EN gates new accepts with cts.
// Revision: 1.0
// ============================================================================
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIV_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [DIV_W-1:0]           baud_div,
  input  logic                       cts,
  output logic                       stx,
  output logic                       rts,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int GID_W  = $clog2(NUM_REQ);
  localparam int DBIT_W = $clog2(DATA_BITS);

  state_e             state_q, state_d;
  logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0]   grant_q, grant_d;
  logic [DBIT_W-1:0]  dbit_q, dbit_d;
  logic               rts_q;

  logic               gate;
  logic               found;
  logic               accept;
  logic [GID_W-1:0]   win;
  logic [DATA_BITS-1:0] win_byte;
  logic               ser_tick;
  logic               ser_done;

`ifdef UART_TX_SCHED_CTS_EN
  assign gate = cts;
`else
  logic unused_cts;
  assign unused_cts = cts;
  assign gate       = 1'b1;
`endif

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[GID_W'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
        found = 1'b1;
        win   = GID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign accept    = rst_n && gate && found && (state_q == IDLE);
  assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;
  assign win_byte  = req_data[8*win +: 8];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    dbit_d   = dbit_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = START;
          rr_ptr_d = GID_W'((int'(win) + 1) % NUM_REQ);
          grant_d  = win;
          dbit_d   = '0;
        end
      end
      START: begin
        if (ser_tick) state_d = DATA;
      end
      DATA: begin
        if (ser_tick) begin
          if (dbit_q == DBIT_W'(DATA_BITS - 1)) state_d = STOP;
          else                                  dbit_d  = dbit_q + 1'b1;
        end
      end
      STOP: begin
        if (ser_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      dbit_q   <= '0;
      rts_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      dbit_q   <= dbit_d;
      rts_q    <= (|req_valid) | busy;
    end
  end

  assign busy     = (state_q != IDLE);
  assign rts      = rts_q;
  assign grant_id = grant_q;

  uart_tx_ser #(
    .DIV_W (DIV_W)
  ) u_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .byte_i (win_byte),
    .div_i  (baud_div),
    .stx_o  (stx),
    .tick_o (ser_tick),
    .done_o (ser_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_tx_sched : directed self-checking bench for uart_tx_sched
// Revision: 1.0
// ============================================================================
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [15:0] baud_div = '0;
  logic        cts = 1'b1;
  logic        stx, rts, busy;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_sched #(.NUM_REQ(4), .DIV_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .baud_div  (baud_div),
    .cts       (cts),
    .stx       (stx),
    .rts       (rts),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // returns just after the accepting clock edge
  task automatic wait_accept(output int idx, output int t);
    idx = -1;
    t   = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        t = cyc;
        for (int i = 0; i < 4; i++) if (req_ready[i]) idx = i;
        check("ready_onehot", $countones(req_ready), 1);
        break;
      end
    end
    if (idx < 0) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("wait_idle", busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, t, t0, t1, n;
    logic [9:0] fr;
    int exp_rr [5];

    // reset state with requests pending
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_stx", stx, 1);
    check("rst_busy", busy, 0);
    check("rst_rts", rts, 0);
    check("rst_gid", grant_id, 0);

    // single frame, div=3, 0xA5 from requester 0
    do_reset();
    baud_div      = 16'd3;
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    wait_accept(idx, t);
    check("sf_grant", idx, 0);
    check("sf_gid", grant_id, 0);
    req_valid = '0;
    req_data  = '0;
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("sf_stx", stx, fr[k/4]);
      check("sf_busy", busy, 1);
      if (k == 20) check("sf_rts", rts, 1);
    end
    @(negedge clk);
    check("sf_end_busy", busy, 0);
    check("sf_end_stx", stx, 1);

    // round robin, all valid, div=0
    do_reset();
    baud_div  = 16'd0;
    req_data  = 32'h44332211;
    req_valid = 4'b1111;
    exp_rr    = '{0, 1, 2, 3, 0};
    t0 = 0;
    for (int g = 0; g < 5; g++) begin
      wait_accept(idx, t);
      check("rr_grant", idx, exp_rr[g]);
      check("rr_gid", grant_id, exp_rr[g]);
      if (g > 0) check("rr_gap", t - t0, 11);
      t0 = t;
    end
    req_valid = '0;
    wait_idle();

    // skipping: after grant 1 only 0 and 3 valid
    do_reset();
    baud_div  = 16'd0;
    req_valid = 4'b0010;
    wait_accept(idx, t);
    check("sk_grant1", idx, 1);
    req_valid = 4'b1001;
    wait_accept(idx, t);
    check("sk_grant3", idx, 3);
    wait_accept(idx, t);
    check("sk_grant0", idx, 0);
    req_valid = '0;
    wait_idle();

    // reset during DATA bit 3 (div=1: bit 3 starts 8 cycles after frame start)
    do_reset();
    baud_div  = 16'd1;
    req_data  = 32'h00A50000;
    req_valid = 4'b0100;
    wait_accept(idx, t);
    check("rm_grant", idx, 2);
    check("rm_gid", grant_id, 2);
    repeat (9) @(negedge clk);
    check("rm_busy_pre", busy, 1);
    rst_n     = 1'b0;
    req_valid = 4'b0110;
    @(negedge clk);
    check("rm_stx", stx, 1);
    check("rm_busy", busy, 0);
    check("rm_gid0", grant_id, 0);
    check("rm_ready", req_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_accept(idx, t);
    check("rm_first", idx, 1);
    req_valid = '0;
    wait_idle();

    // divisor latched per frame
    do_reset();
    baud_div      = 16'd2;
    req_data[7:0] = 8'hFF;
    req_valid     = 4'b0001;
    wait_accept(idx, t0);
    baud_div = 16'd9;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (stx == 1'b0) n++;
    end
    check("dl_start_len", n, 3);
    wait_accept(idx, t1);
    check("dl_gap", t1 - t0, 31);
    req_valid = '0;
    n = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check("dl_busy_len", n, 100);

`ifdef UART_TX_SCHED_CTS_EN
    // cts gating
    do_reset();
    baud_div        = 16'd0;
    cts             = 1'b0;
    req_data[23:16] = 8'h3C;
    req_valid       = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("cts_blocked", req_ready, 0);
    end
    check("cts_rts", rts, 1);
    @(posedge clk);
    #1;
    cts = 1'b1;
    t0  = cyc;
    wait_accept(idx, t);
    check("cts_grant", idx, 2);
    check("cts_latency", t - t0, 0);
    cts = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check("cts_frame_len", n, 10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("cts_hold", req_ready, 0);
    end
    cts = 1'b1;
    req_valid = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
